// File: rtl/cpc_boot_pkg.sv
// Shared boot-loader definitions: FSM state type and default ROM window constants.
package cpc_boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_SETUP  = 3'd2,
    ST_STROBE = 3'd3,
    ST_NEXT   = 3'd4,
    ST_DONE   = 3'd5
  } boot_state_e;

  // Also consumed by the memory manager to locate the ROM image in SRAM.
  localparam logic [18:0] ROM_LOCATION_DEFAULT = 19'h5C000;
  localparam logic [15:0] ROM_END_DEFAULT      = 16'h4000;

endpackage

// File: rtl/cpc_boot_rom_loader_if.sv
// Four-phase boot-word handshake between the control module (master) and the loader (slave).
interface cpc_boot_rom_loader_if;

  logic [31:0] host_bootdata;
  logic        host_bootdata_req;
  logic        host_bootdata_ack;

  modport master (
    output host_bootdata,
    output host_bootdata_req,
    input  host_bootdata_ack
  );

  modport slave (
    input  host_bootdata,
    input  host_bootdata_req,
    output host_bootdata_ack
  );

endinterface

// File: rtl/cpc_boot_rom_loader_bootword_serializer.sv
// Holds one captured boot word and presents it MSB byte first; the FSM loads and shifts it.
module bootword_serializer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        shift,
  input  logic [31:0] word,
  output logic [7:0]  cur_byte,
  output logic        last
);

  logic [31:0] sr;
  logic [1:0]  idx;

  // Shift register and byte index: load restarts at byte 0, shift moves to the next lower byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr  <= '0;
      idx <= '0;
    end else if (load) begin
      sr  <= word;
      idx <= '0;
    end else if (shift) begin
      sr  <= {sr[23:0], 8'h00};
      idx <= idx + 2'd1;
    end
  end

  assign cur_byte = sr[31:24];
  assign last     = (idx == 2'd3);

endmodule

// File: rtl/cpc_boot_rom_loader.sv
// Boot ROM loader: takes 32-bit words over a four-phase handshake and writes them
// byte by byte into the SRAM ROM window with a timed write strobe.
module cpc_boot_rom_loader
  import cpc_boot_pkg::*;
#(
  parameter bit          CONFIG_ON_STARTUP = 1'b1,
  parameter logic [18:0] ROM_LOCATION      = ROM_LOCATION_DEFAULT,
  parameter logic [15:0] ROM_END           = ROM_END_DEFAULT,
  parameter int unsigned WR_CYCLES         = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  cpc_boot_rom_loader_if.slave         host,
  input  logic                         host_reset,
  output logic [7:0]                   romwrite_data,
  output logic [18:0]                  romwrite_addr,
  output logic                         romwrite_wr,
  output logic                         rom_initialised
);

  localparam logic [3:0] STROBE_LAST = 4'(WR_CYCLES - 1);

  boot_state_e state;
  logic [15:0] count;
  logic [15:0] count_inc;
  logic [18:0] next_addr;
  logic [3:0]  timer;
  logic        ack;
  logic        req;
  logic        ser_load;
  logic        ser_shift;
  logic        ser_last;

  assign req                    = host.host_bootdata_req;
  assign host.host_bootdata_ack = ack;

  // Serializer control and address arithmetic; host_reset suppresses any load/shift.
  always_comb begin
    count_inc = count + 16'd1;
    next_addr = ROM_LOCATION + {3'b000, count};
    ser_load  = 1'b0;
    ser_shift = 1'b0;
    if (!host_reset) begin
      ser_load  = (state == ST_WAIT) && (count != ROM_END) && req && !ack;
      ser_shift = (state == ST_NEXT) && !ser_last;
    end
  end

  bootword_serializer u_ser (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (ser_load),
    .shift    (ser_shift),
    .word     (host.host_bootdata),
    .cur_byte (romwrite_data),
    .last     (ser_last)
  );

  // Load FSM with handshake, byte counter and strobe timer; host_reset overrides everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= CONFIG_ON_STARTUP ? ST_WAIT : ST_DONE;
      ack             <= 1'b0;
      romwrite_wr     <= 1'b0;
      romwrite_addr   <= ROM_LOCATION;
      count           <= '0;
      timer           <= '0;
      rom_initialised <= !CONFIG_ON_STARTUP;
    end else if (host_reset) begin
      state           <= ST_WAIT;
      ack             <= 1'b0;
      romwrite_wr     <= 1'b0;
      romwrite_addr   <= ROM_LOCATION;
      count           <= '0;
      timer           <= '0;
      rom_initialised <= 1'b0;
    end else begin
      // ack is released once req has been sampled low, in every state.
      if (ack && !req) ack <= 1'b0;
      case (state)
        ST_WAIT: begin
          if (count == ROM_END) begin
            state           <= ST_DONE;
            rom_initialised <= 1'b1;
          end else if (req && !ack) begin
            ack           <= 1'b1;
            romwrite_addr <= next_addr;
            state         <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          romwrite_wr <= 1'b1;
          timer       <= '0;
          state       <= ST_STROBE;
        end
        ST_STROBE: begin
          if (timer == STROBE_LAST) begin
            romwrite_wr <= 1'b0;
            count       <= count_inc;
            // Reaching the byte budget mid-word drops the remaining bytes.
            if (count_inc == ROM_END) begin
              state           <= ST_DONE;
              rom_initialised <= 1'b1;
            end else begin
              state <= ST_NEXT;
            end
          end else begin
            timer <= timer + 4'd1;
          end
        end
        ST_NEXT: begin
          if (ser_last) begin
            state <= ST_WAIT;
          end else begin
            romwrite_addr <= next_addr;
            state         <= ST_SETUP;
          end
        end
        ST_DONE: begin
          romwrite_wr     <= 1'b0;
          rom_initialised <= 1'b1;
          // Late words are acknowledged and dropped so the host never stalls.
          if (req && !ack) ack <= 1'b1;
        end
        default: state <= ST_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_cpc_boot_rom_loader.sv
// Bench for cpc_boot_rom_loader: three parameterisations checked against a byte-stream model.
module tb_cpc_boot_rom_loader;

  localparam int unsigned WR = 2;
  localparam int NI  = 3;
  localparam int GAP = 2;   // NEXT + SETUP low cycles between strobes of one word

  function automatic bit cfg_of(input int i);
    return (i != 2);
  endfunction
  function automatic logic [18:0] loc_of(input int i);
    return (i == 2) ? 19'h7FFFE : 19'h5C000;
  endfunction
  function automatic int end_of(input int i);
    return (i == 0) ? 8 : ((i == 1) ? 6 : 4);
  endfunction

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [31:0]   d_data [NI];
  logic [NI-1:0] d_req;
  logic [NI-1:0] d_hr;
  logic [7:0]    o_data [NI];
  logic [18:0]   o_addr [NI];
  logic [NI-1:0] o_wr;
  logic [NI-1:0] o_ack;
  logic [NI-1:0] o_init;

  int total = 0;
  int bad   = 0;
  bit stop  = 1'b0;

  // Model: expected byte stream per instance, observed write log, strobe bookkeeping.
  logic [7:0]  expb [NI][64];
  int          qh [NI];
  int          qt [NI];
  logic [26:0] wlog [NI][64];
  int          written [NI];
  int          plen [NI];
  int          low [NI];
  bit          loaded [NI];
  bit          armed [NI];
  logic        pwr [NI];
  logic [7:0]  pdata [NI];
  logic [18:0] paddr [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    cpc_boot_rom_loader_if bus ();
    assign bus.host_bootdata     = d_data[g];
    assign bus.host_bootdata_req = d_req[g];
    assign o_ack[g]              = bus.host_bootdata_ack;

    cpc_boot_rom_loader #(
      .CONFIG_ON_STARTUP (cfg_of(g)),
      .ROM_LOCATION      (loc_of(g)),
      .ROM_END           (16'(end_of(g))),
      .WR_CYCLES         (WR)
    ) u_dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .host            (bus),
      .host_reset      (d_hr[g]),
      .romwrite_data   (o_data[g]),
      .romwrite_addr   (o_addr[g]),
      .romwrite_wr     (o_wr[g]),
      .rom_initialised (o_init[g])
    );
  end

  task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d: got %h want %h (t=%0t)", name, i, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input int i, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s inst=%0d: got %h want no such event (t=%0t)", name, i, act, $time);
  endtask

  task automatic mon_step(input int i);
    logic [18:0] ea;
    if (d_hr[i]) begin
      // host_reset was sampled at the last rising edge
      check("hr_wr", i, 32'(o_wr[i]), 32'd0);
      check("hr_ack", i, 32'(o_ack[i]), 32'd0);
      check("hr_init", i, 32'(o_init[i]), 32'd0);
      written[i] = 0; loaded[i] = 1'b0; armed[i] = 1'b1;
      qh[i] = 0; qt[i] = 0; plen[i] = 0; low[i] = 0;
    end else begin
      if (o_wr[i] && !pwr[i]) begin
        ea = loc_of(i) + 19'(written[i]);
        check("setup_addr_stable", i, 32'(o_addr[i]), 32'(paddr[i]));
        check("setup_data_stable", i, 32'(o_data[i]), 32'(pdata[i]));
        if (!armed[i] || written[i] >= end_of(i)) fail("unexpected_write", i, 32'(o_addr[i]));
        check("wr_addr", i, 32'(o_addr[i]), 32'(ea));
        if (qh[i] < qt[i]) check("wr_data", i, 32'(o_data[i]), 32'(expb[i][qh[i]]));
        else fail("unqueued_write", i, 32'(o_data[i]));
        if (written[i] % 4 != 0) check("byte_gap", i, 32'(low[i]), 32'(GAP));
        if (written[i] < 64) wlog[i][written[i]] = {o_addr[i], o_data[i]};
        plen[i] = 1;
      end else if (o_wr[i] && pwr[i]) begin
        check("strobe_addr_stable", i, 32'(o_addr[i]), 32'(paddr[i]));
        check("strobe_data_stable", i, 32'(o_data[i]), 32'(pdata[i]));
        plen[i]++;
      end else if (!o_wr[i] && pwr[i]) begin
        check("wr_width", i, 32'(plen[i]), 32'(WR));
        written[i]++;
        if (qh[i] < qt[i]) qh[i]++;
        if (written[i] == end_of(i)) loaded[i] = 1'b1;
        low[i] = 1;
      end else begin
        low[i]++;
      end
      check("rom_init", i, 32'(o_init[i]), 32'(loaded[i]));
    end
    pwr[i] = o_wr[i]; paddr[i] = o_addr[i]; pdata[i] = o_data[i];
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_word(input int i, input logic [31:0] w, input int hold, input bit expect_wr);
    int n;
    for (int b = 0; b < 4; b++) begin
      expb[i][qt[i]] = w[31-8*b -: 8];
      qt[i]++;
    end
    tick();
    d_data[i] = w;
    d_req[i]  = 1'b1;
    n = 0;
    while (!o_ack[i] && n < 60) begin tick(); n++; end
    check("ack_rise", i, 32'(o_ack[i]), 32'd1);
    if (expect_wr) begin
      tick();
      check("capture_to_wr", i, 32'(o_wr[i]), 32'd1);
    end
    if (hold > 0) begin
      repeat (hold) tick();
      check("ack_held", i, 32'(o_ack[i]), 32'd1);
    end
    d_req[i] = 1'b0;
    n = 0;
    while (o_ack[i] && n < 10) begin tick(); n++; end
    check("ack_fall", i, 32'(o_ack[i]), 32'd0);
  endtask

  task automatic wait_init(input int i);
    int n;
    n = 0;
    while (!o_init[i] && n < 300) begin tick(); n++; end
    check("load_complete", i, 32'(o_init[i]), 32'd1);
  endtask

  task automatic hr_pulse(input int i);
    d_hr[i] = 1'b1;
    tick();
    d_hr[i] = 1'b0;
  endtask

  task automatic run_tests();
    logic [31:0] w, wa, wb;
    int n;
    // Instance 0: two literal words, ROM_END=8
    send_word(0, 32'h11223344, 0, 1'b1);
    send_word(0, 32'h55667788, 0, 1'b0);
    wait_init(0);
    check("inst0_count", 0, 32'(written[0]), 32'd8);
    check("inst0_first", 0, 32'(wlog[0][0]), 32'({19'h5C000, 8'h11}));
    check("inst0_fourth", 0, 32'(wlog[0][3]), 32'({19'h5C003, 8'h44}));
    check("inst0_last", 0, 32'(wlog[0][7]), 32'({19'h5C007, 8'h88}));

    // Instance 1: ROM_END=6 truncates the second word, then a word after DONE
    send_word(1, 32'h11223344, 0, 1'b1);
    send_word(1, 32'h55667788, 0, 1'b0);
    wait_init(1);
    check("inst1_count", 1, 32'(written[1]), 32'd6);
    check("inst1_last", 1, 32'(wlog[1][5]), 32'({19'h5C005, 8'h66}));
    send_word(1, 32'hAABBCCDD, 0, 1'b0);
    repeat (20) tick();
    check("inst1_after_done", 1, 32'(written[1]), 32'd6);

    // Instance 2: no startup load, then a wrapped load after host_reset
    repeat (10) tick();
    check("inst2_idle_init", 2, 32'(o_init[2]), 32'd1);
    check("inst2_idle_count", 2, 32'(written[2]), 32'd0);
    hr_pulse(2);
    w = $urandom;
    send_word(2, w, 0, 1'b1);
    wait_init(2);
    check("wrap_a0", 2, 32'(wlog[2][0][26:8]), 32'h7FFFE);
    check("wrap_a1", 2, 32'(wlog[2][1][26:8]), 32'h7FFFF);
    check("wrap_a2", 2, 32'(wlog[2][2][26:8]), 32'h00000);
    check("wrap_a3", 2, 32'(wlog[2][3][26:8]), 32'h00001);
    check("wrap_d3", 2, 32'(wlog[2][3][7:0]), 32'(w[7:0]));

    // Instance 0: reload, abort during byte 3 strobe, reload again with req held over a word
    hr_pulse(0);
    w = $urandom;
    send_word(0, w, 0, 1'b1);
    n = 0;
    while (!(written[0] == 2 && o_wr[0]) && n < 100) begin tick(); n++; end
    if (n >= 100) fail("byte3_timeout", 0, 32'(written[0]));
    hr_pulse(0);
    tick();
    check("abort_wr", 0, 32'(o_wr[0]), 32'd0);
    check("abort_init", 0, 32'(o_init[0]), 32'd0);
    wa = $urandom;
    wb = $urandom;
    send_word(0, wa, 30, 1'b1);
    send_word(0, wb, 0, 1'b0);
    wait_init(0);
    check("reload_count", 0, 32'(written[0]), 32'd8);
    check("reload_first", 0, 32'(wlog[0][0]), 32'({19'h5C000, wa[31:24]}));
    check("reload_last", 0, 32'(wlog[0][7]), 32'({19'h5C007, wb[7:0]}));
    repeat (5) tick();
  endtask

  initial begin
    d_req = '0;
    d_hr  = '0;
    for (int i = 0; i < NI; i++) begin
      d_data[i] = '0;
      qh[i] = 0; qt[i] = 0; written[i] = 0; plen[i] = 0; low[i] = 0;
      loaded[i] = !cfg_of(i); armed[i] = cfg_of(i);
      pwr[i] = 1'b0; pdata[i] = 8'h00; paddr[i] = loc_of(i);
    end
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #20;
    for (int i = 0; i < NI; i++) begin
      check("rst_ack", i, 32'(o_ack[i]), 32'd0);
      check("rst_wr", i, 32'(o_wr[i]), 32'd0);
      check("rst_data", i, 32'(o_data[i]), 32'h00);
      check("rst_addr", i, 32'(o_addr[i]), 32'(loc_of(i)));
      check("rst_init", i, 32'(o_init[i]), 32'(!cfg_of(i)));
    end
    tick();
    reset_n = 1'b1;
    fork
      begin
        while (!stop) begin
          @(negedge clk);
          for (int i = 0; i < NI; i++) mon_step(i);
        end
      end
      begin
        run_tests();
        stop = 1'b1;
      end
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
